// File: rtl/iwdg_refresh_ctrl_if.sv
// Signal bundle between the core-side refresh controller and its software/IWDG peers.
// The master modport is the controller end; slave is the software/watchdog end.
interface iwdg_refresh_ctrl_if;
  logic        en;
  logic        kick;
  logic        freeze;
  logic        Reset_signal;
  logic        bite_clr;
  logic [15:0] IWDG_KR;
  logic        aCore_signal;
  logic        i_sel;
  logic [2:0]  state_o;
  logic [1:0]  miss_cnt;
  logic        bite_flag;

  modport master (
    input  en, kick, freeze, Reset_signal, bite_clr,
    output IWDG_KR, aCore_signal, i_sel, state_o, miss_cnt, bite_flag
  );

  modport slave (
    output en, kick, freeze, Reset_signal, bite_clr,
    input  IWDG_KR, aCore_signal, i_sel, state_o, miss_cnt, bite_flag
  );
endinterface

// File: rtl/iwdg_refresh_ctrl.sv
// IWDG key/refresh initiator: refresh pulses only while software kicks, stops after MAX_MISS misses.
// Outputs registered one cycle after their cause; the bite input adds two synchroniser stages.
module iwdg_refresh_ctrl #(
  parameter int REFRESH_PERIOD = 256,
  parameter int REFRESH_W      = 2,
  parameter int ARM_CYC        = 3,
  parameter int MAX_MISS       = 3
) (
  input logic                 CLOCK,
  input logic                 sys_rst,
  iwdg_refresh_ctrl_if.master bus
);

  localparam int CW = $clog2(REFRESH_PERIOD);
  localparam int AW = $clog2(ARM_CYC + 1);
  localparam int WW = $clog2(REFRESH_W + 1);
  localparam logic [CW-1:0] CNT_LAST = CW'(REFRESH_PERIOD - 1);
  localparam logic [AW-1:0] ARM_LAST = AW'(ARM_CYC - 1);
  localparam logic [WW-1:0] W_LAST   = WW'(REFRESH_W - 1);
  localparam logic [1:0]    MISS_MAX = 2'(MAX_MISS);
  localparam logic [15:0]   RUN_KEY  = 16'hCCCC;

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    ARM     = 3'd1,
    RUN     = 3'd2,
    REFRESH = 3'd3,
    STARVE  = 3'd4,
    BITTEN  = 3'd5
  } state_t;

  state_t        state;
  logic [15:0]   kr_q;
  logic          acore_q;
  logic          isel_q;
  logic [1:0]    miss_q;
  logic          flag_q;
  logic [CW-1:0] cnt;
  logic [AW-1:0] arm_cnt;
  logic [WW-1:0] w_cnt;
  logic          kick_seen;
  logic          rs_meta;
  logic          rs_sync;
  logic          rs_prev;
  logic          frozen;
  logic          active;
  logic          bite_ev;
  logic [1:0]    miss_inc;

  assign frozen   = bus.freeze;
  assign active   = (state == ARM) || (state == RUN) || (state == REFRESH) || (state == STARVE);
  assign bite_ev  = rs_sync & ~rs_prev;
  assign miss_inc = miss_q + 2'd1;

  assign bus.IWDG_KR      = kr_q;
  assign bus.aCore_signal = acore_q;
  assign bus.i_sel        = isel_q;
  assign bus.state_o      = state;
  assign bus.miss_cnt     = miss_q;
  assign bus.bite_flag    = flag_q;

  // Moves to state s and registers the output levels that state drives.
  task automatic enter(input state_t s);
    state   <= s;
    kr_q    <= (s == IDLE || s == BITTEN) ? 16'h0000 : RUN_KEY;
    acore_q <= (s == ARM) || (s == RUN) || (s == STARVE);
    isel_q  <= frozen || (s == IDLE) || (s == BITTEN);
  endtask

  always_ff @(posedge CLOCK or negedge sys_rst) begin
    if (!sys_rst) begin
      state     <= IDLE;
      kr_q      <= 16'h0000;
      acore_q   <= 1'b0;
      isel_q    <= 1'b1;
      miss_q    <= 2'd0;
      flag_q    <= 1'b0;
      cnt       <= '0;
      arm_cnt   <= '0;
      w_cnt     <= '0;
      kick_seen <= 1'b0;
      rs_meta   <= 1'b0;
      rs_sync   <= 1'b0;
      rs_prev   <= 1'b0;
    end else begin
      rs_meta <= bus.Reset_signal;
      rs_sync <= rs_meta;
      rs_prev <= rs_sync;
      enter(state);
      if (active && bite_ev) begin
        enter(BITTEN);
        flag_q    <= 1'b1;
        kick_seen <= 1'b0;
      end else if (!bus.en && state != BITTEN) begin
        enter(IDLE);
        miss_q    <= 2'd0;
        kick_seen <= 1'b0;
        cnt       <= '0;
        arm_cnt   <= '0;
        w_cnt     <= '0;
      end else begin
        if (bus.kick && active) kick_seen <= 1'b1;
        case (state)
          IDLE: if (bus.en) begin
            enter(ARM);
            arm_cnt <= '0;
          end
          ARM: if (arm_cnt == ARM_LAST) begin
            enter(RUN);
            cnt <= '0;
          end else begin
            arm_cnt <= arm_cnt + 1'b1;
          end
          RUN: if (!frozen) begin
            if (cnt == CNT_LAST) begin
              // A kick arriving on the decision cycle itself still counts.
              kick_seen <= 1'b0;
              cnt       <= '0;
              if (kick_seen || bus.kick) begin
                enter(REFRESH);
                w_cnt  <= '0;
                miss_q <= 2'd0;
              end else begin
                miss_q <= miss_inc;
                if (miss_inc == MISS_MAX) enter(STARVE);
              end
            end else begin
              cnt <= cnt + 1'b1;
            end
          end
          REFRESH: if (!frozen) begin
            if (w_cnt == W_LAST) begin
              enter(RUN);
              cnt <= '0;
            end else begin
              w_cnt <= w_cnt + 1'b1;
            end
          end
          // The recovering kick is consumed by this refresh, not carried into the next period.
          STARVE: if (bus.kick) begin
            enter(REFRESH);
            w_cnt     <= '0;
            miss_q    <= 2'd0;
            kick_seen <= 1'b0;
          end
          BITTEN: if (bus.bite_clr) begin
            enter(IDLE);
            flag_q <= 1'b0;
          end
          default: enter(IDLE);
        endcase
      end
    end
  end

endmodule
